// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: chains an external 16-bit adder across LSW-first words for N x 16-bit add/subtract.
// Optional MWADD_OP_COUNT_EN builds the completed-operation counter driven onto op_count.
module multiword_add_sequencer #(
    parameter int MAX_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_first,
    input  logic        in_last,
    input  logic        in_sub,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_last,
    output logic        out_carry,
    output logic        out_ovf,
    output logic        out_zero,
    output logic        err,
    output logic [15:0] op_count
);
    localparam int CW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_carry;
    logic          r_sub;
    logic          r_zero_acc;
    logic          r_out_valid;
    logic [15:0]   r_out_sum;
    logic          r_out_last;
    logic          r_out_carry;
    logic          r_out_ovf;
    logic          r_out_zero;
    logic          r_err;

    logic w_accept;
    logic w_first;
    logic w_sub;
    logic w_forced;
    logic w_last;
    logic w_zero_next;
    logic w_err;

    assign w_first     = in_first || (r_state == IDLE);
    assign w_sub       = w_first ? in_sub : r_sub;
    assign in_ready    = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    // r_cnt holds words already accepted, so MAX_WORDS-1 means this is the MAX_WORDS-th word
    assign w_forced    = !w_first && (r_cnt == CW'(MAX_WORDS - 1));
    assign w_last      = in_last || w_forced;
    assign w_zero_next = (w_first || r_zero_acc) && (add_sum == 16'h0000);
    assign w_err       = (!in_first && r_state == IDLE) || (in_first && r_state == BUSY) || (w_forced && !in_last);

    assign add_a   = in_a;
    assign add_b   = in_b ^ {16{w_sub}};
    assign add_cin = w_first ? w_sub : r_carry;

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_last  = r_out_last;
    assign out_carry = r_out_carry;
    assign out_ovf   = r_out_ovf;
    assign out_zero  = r_out_zero;
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_zero_acc  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= 16'h0000;
            r_out_last  <= 1'b0;
            r_out_carry <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_zero  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= add_sum;
                r_carry     <= add_cout;
                r_sub       <= w_sub;
                r_zero_acc  <= w_zero_next;
                r_cnt       <= w_first ? CW'(1) : r_cnt + CW'(1);
                r_out_last  <= w_last;
                r_out_carry <= w_last && add_cout;
                r_out_ovf   <= w_last && (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);
                r_out_zero  <= w_last && w_zero_next;
                r_state     <= w_last ? IDLE : BUSY;
                if (w_err)
                    r_err <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef MWADD_OP_COUNT_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_op_count <= 16'h0000;
        else if (w_accept && w_last)
            r_op_count <= r_op_count + 16'h0001;
    end

    assign op_count = r_op_count;
`else
    assign op_count = 16'h0000;
`endif
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// tb_multiword_add_sequencer: directed vectors with a scoreboard queue and an independent output monitor.
// Includes a behavioural 16-bit adder standing in for the ripple carry adder.
module tb_multiword_add_sequencer;
    typedef struct packed {
        logic [15:0] s;
        logic        l;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        in_sub = 1'b0;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_last;
    logic        out_carry;
    logic        out_ovf;
    logic        out_zero;
    logic        err;
    logic [15:0] op_count;
    logic [16:0] w_add;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    multiword_add_sequencer #(.MAX_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_last(out_last),
        .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero), .err(err), .op_count(op_count)
    );

    assign w_add    = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};
    assign add_sum  = w_add[15:0];
    assign add_cout = w_add[16];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic f, input logic l,
                        input logic s, input logic [15:0] es, input logic el, input logic ec,
                        input logic eo, input logic ez, input bit push = 1'b1);
        bit acc = 1'b0;
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_first = f; in_last = l; in_sub = s;
        if (push) q.push_back('{es, el, ec, eo, ez});
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'(n), 32'(0));
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(q.size()), 32'(0));
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_word: got %h expected none", out_sum);
            end else begin
                chk("out_word", {12'h0, out_sum, out_last, out_carry, out_ovf, out_zero}, {12'h0, q.pop_front()});
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_fields", {10'h0, out_sum, out_last, out_carry, out_ovf, out_zero, err}, 32'(0));
        chk("rst_op_count", 32'(op_count), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // 0x0001_FFFF + 0x0000_0001
        send(16'hFFFF, 16'h0001, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
        send(16'h0001, 16'h0000, 0, 1, 0, 16'h0002, 1, 0, 0, 0);
        // 5 - 5 over two words
        send(16'h0005, 16'h0005, 1, 0, 1, 16'h0000, 0, 0, 0, 0);
        send(16'h0000, 16'h0000, 0, 1, 0, 16'h0000, 1, 1, 0, 1);
        send(16'h7FFF, 16'h0001, 1, 1, 0, 16'h8000, 1, 0, 1, 0);
        send(16'hFFFF, 16'h0001, 1, 1, 0, 16'h0000, 1, 1, 0, 1);
        // four-word add with a three-cycle consumer stall after the second word
        send(16'hFFFF, 16'h0001, 1, 0, 0, 16'h0000, 0, 0, 0, 0);
        send(16'h0002, 16'h0000, 0, 0, 0, 16'h0003, 0, 0, 0, 0);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(in_ready), 32'(0));
                    chk("stall_hold", {15'h0, out_valid, out_sum}, {15'h0, 1'b1, 16'h0003});
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
            begin
                send(16'h0003, 16'h0000, 0, 0, 0, 16'h0003, 0, 0, 0, 0);
                t0 = $time;
                send(16'h0004, 16'h0000, 0, 1, 0, 16'h0004, 1, 0, 0, 0);
                chk("resume_rate", 32'($time - t0), 32'(10));
            end
        join
        drain();
        chk("no_err_yet", 32'(err), 32'(0));
        // five words with no in_last: fourth is forced last, fifth starts a new operation
        send(16'h0001, 16'h0000, 1, 0, 0, 16'h0001, 0, 0, 0, 0);
        send(16'h0001, 16'h0000, 0, 0, 0, 16'h0001, 0, 0, 0, 0);
        send(16'h0001, 16'h0000, 0, 0, 0, 16'h0001, 0, 0, 0, 0);
        send(16'h0001, 16'h0000, 0, 0, 0, 16'h0001, 1, 0, 0, 0);
        chk("forced_last_err", 32'(err), 32'(1));
        send(16'h0001, 16'h0000, 0, 0, 0, 16'h0001, 0, 0, 0, 0);
        // in_first while busy restarts a subtract with Cin=1; sub stays latched on the last word
        in_a = 16'h0000; in_b = 16'h0000; in_first = 1'b1; in_sub = 1'b1;
        #1;
        chk("restart_cin", 32'(add_cin), 32'(1));
        send(16'h0000, 16'h0000, 1, 0, 1, 16'h0000, 0, 0, 0, 0);
        send(16'h0000, 16'h0001, 0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
        drain();
        chk("err_sticky", 32'(err), 32'(1));
        // reset while a word of an unfinished operation is pending
        out_ready = 1'b0;
        send(16'h1234, 16'h0001, 1, 0, 0, 16'h0000, 0, 0, 0, 0, 1'b0);
        chk("pending_before_rst", {15'h0, out_valid, out_sum}, {15'h0, 1'b1, 16'h1235});
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", {9'h0, out_valid, out_sum, out_last, out_carry, out_ovf, out_zero, err}, 32'(0));
        chk("midrst_op_count", 32'(op_count), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 0, 1);
`ifdef MWADD_OP_COUNT_EN
        chk("op_count_3", 32'(op_count), 32'(3));
        for (int i = 0; i < 65532; i++) send(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 0, 1);
        chk("op_count_max", 32'(op_count), 32'h0000FFFF);
        send(16'h0000, 16'h0000, 1, 1, 0, 16'h0000, 1, 0, 0, 1);
        chk("op_count_wrap", 32'(op_count), 32'(0));
`else
        chk("op_count_off", 32'(op_count), 32'(0));
`endif
        chk("err_after_rst", 32'(err), 32'(0));
        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
